multu: RTL and testbench

Sequential unsigned integer multiplier, the complement of the team's `divu` divider, sharing its `start`/`busy` handshake so both can sit side by side behind the ALU's multi-cycle issue port. It captures two WIDTH-bit operands on `start` and runs a radix-2 shift-add loop, one multiplier bit per clock. It returns the full 2·WIDTH-bit product, announces completion with a one-cycle `done` pulse, and holds the result until the next operation completes.

---
 rtl/multu_pkg.sv | 28 ++
 rtl/multu_step.sv | 40 ++++
 rtl/multu.sv | 163 ++++++++++++++++
 tb/tb_multu.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multu_pkg.sv
// -----------------------------------------------------------------------------
// multu_pkg
//   Shared definitions for the sequential unsigned multiplier (multu).
//
//   Contents:
//     multu_state_e        - FSM state encoding (MULTU_IDLE, MULTU_RUN)
//     MULTU_DEFAULT_WIDTH  - default operand width in bits
//     multu_cnt_w()        - width of the iteration counter, which must be
//                            able to hold the value WIDTH itself
//
//   Optional build macro: MULTU_EARLY_TERM_EN (used by multu.sv, not here).
// -----------------------------------------------------------------------------
package multu_pkg;

  typedef enum logic {
    MULTU_IDLE = 1'b0,
    MULTU_RUN  = 1'b1
  } multu_state_e;

  localparam int MULTU_DEFAULT_WIDTH = 32;

  // The counter is loaded with WIDTH and counts down to 0, so it needs
  // enough bits to represent WIDTH (not WIDTH-1).
  function automatic int multu_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : multu_pkg

// File: rtl/multu_step.sv
// -----------------------------------------------------------------------------
// multu_step
//   One radix-2 shift-add iteration of the multiplier, purely combinational.
//
//   The product register P holds {P_high, P_low}. P_low initially holds the
//   multiplier; its bit 0 selects whether the multiplicand M is added into
//   P_high. The add is formed at WIDTH+1 bits so the carry out of P_high is
//   kept, and the whole {carry, P_high, P_low} is then shifted right by one,
//   which drops the multiplier bit just consumed and moves the carry into
//   the top of P_high.
//
//   Parameters:
//     WIDTH   operand width in bits
//   Ports:
//     p       in   2*WIDTH  current product register {P_high, P_low}
//     m       in   WIDTH    multiplicand
//     p_next  out  2*WIDTH  product register after this iteration
// -----------------------------------------------------------------------------
module multu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] p,
  input  logic [WIDTH-1:0]   m,
  output logic [2*WIDTH-1:0] p_next
);

  logic [WIDTH:0] sum;  // {carry, new P_high}

  always_comb begin
    if (p[0]) begin
      sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m};
    end else begin
      sum = {1'b0, p[2*WIDTH-1:WIDTH]};
    end
    // Right shift of {carry, P_high, P_low}: the carry lands in bit 2W-1
    // and P_low[0] (the consumed multiplier bit) falls off the bottom.
    p_next = {sum, p[WIDTH-1:1]};
  end

endmodule : multu_step

// File: rtl/multu.sv
// -----------------------------------------------------------------------------
// multu
//   Sequential unsigned integer multiplier, radix-2 shift-add, one multiplier
//   bit per clock. Shares the start/busy handshake of the divu divider.
//
//   Handshake: start is sampled only on a rising clk edge where busy=0; such
//   an edge accepts a and b. busy is 1 from the next cycle while iterations
//   run. Completion raises done for exactly one cycle, in the same cycle busy
//   returns to 0, and z holds the product from then until the next
//   completion. start seen while busy=1 is ignored. Because busy is already
//   0 in the done cycle, a start in that cycle is accepted (back-to-back).
//
//   Parameters:
//     WIDTH      operand width in bits (even, >= 4)
//   Ports:
//     clk        in   1        rising-edge clock
//     resetn     in   1        asynchronous active-low reset
//     start      in   1        operation request
//     a          in   WIDTH    multiplicand (unsigned)
//     b          in   WIDTH    multiplier (unsigned)
//     z          out  2*WIDTH  registered product a*b
//     busy       out  1        iteration in progress
//     done       out  1        one-cycle completion pulse
//     fsm_state  out  enum     current FSM state, for observation/checkers
//
//   Build option:
//     MULTU_EARLY_TERM_EN  when defined, RUN ends as soon as the multiplier
//                          bits not yet consumed are all zero; the last
//                          cycle shifts P right by the remaining count so
//                          the product matches the full-length loop.
//                          Latency becomes max(1, msb_index(b)+1) cycles.
//
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module multu
  import multu_pkg::*;
#(
  parameter int WIDTH = MULTU_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] z,
  output logic               busy,
  output logic               done,
  output multu_state_e       fsm_state
);

  localparam int              CW       = multu_cnt_w(WIDTH);
  localparam logic [CW-1:0]   CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  multu_state_e       state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;        // captured multiplicand
  logic [2*WIDTH-1:0] p_q, p_d;        // product register {P_high, P_low}
  logic [CW-1:0]      cnt_q, cnt_d;    // iterations still to run
  logic [2*WIDTH-1:0] z_q, z_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] p_step;          // P after one shift-add
  logic [2*WIDTH-1:0] p_final;         // value written to z on the last cycle
  logic               last;            // this RUN cycle completes the operation

  multu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p      (p_q),
    .m      (m_q),
    .p_next (p_step)
  );

`ifdef MULTU_EARLY_TERM_EN
  // After this cycle's step, cnt_q-1 multiplier bits remain unconsumed in
  // the low end of P_low. If they are all zero, every remaining iteration
  // would be a pure right shift, so those shifts are applied at once.
  // rem is meaningless in IDLE (cnt_q=0); last/p_final are only used in RUN.
  logic [CW-1:0]    rem;
  logic [WIDTH-1:0] rem_mask;

  always_comb begin
    rem      = cnt_q - CNT_ONE;
    rem_mask = ~({WIDTH{1'b1}} << rem);
    p_final  = p_step >> rem;
    last     = (cnt_q == CNT_ONE) || ((p_step[WIDTH-1:0] & rem_mask) == '0);
  end
`else
  always_comb begin
    p_final = p_step;
    last    = (cnt_q == CNT_ONE);
  end
`endif

  // Next-state and next-register logic.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      MULTU_IDLE: begin
        if (start) begin
          m_d     = a;
          p_d     = {{WIDTH{1'b0}}, b};
          cnt_d   = CNT_FULL;
          busy_d  = 1'b1;
          state_d = MULTU_RUN;
        end
      end

      MULTU_RUN: begin
        p_d   = p_step;
        cnt_d = cnt_q - CNT_ONE;
        if (last) begin
          z_d     = p_final;
          p_d     = p_final;
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = MULTU_IDLE;
        end
      end

      default: begin
        state_d = MULTU_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation silently.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= MULTU_IDLE;
      m_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign z         = z_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fsm_state = state_q;

endmodule : multu

// File: tb/tb_multu.sv
// -----------------------------------------------------------------------------
// tb_multu
//   Self-checking bench for multu (WIDTH=32). Driver tasks issue operations
//   and push the expected product and latency into queues; a monitor on the
//   falling clock edge pops and compares each time done is seen.
//   Honours MULTU_EARLY_TERM_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_multu;
  import multu_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic             start;
  logic [W-1:0]     a, b;
  logic [2*W-1:0]   z;
  logic             busy, done;
  multu_state_e     fsm_state;

  multu #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .a         (a),
    .b         (b),
    .z         (z),
    .busy      (busy),
    .done      (done),
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];
  int             busy_run = 0;

  task automatic check(input string name, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] ob);
    int hi;
    hi = 0;
    for (int i = 0; i < W; i++) if (ob[i]) hi = i + 1;
`ifdef MULTU_EARLY_TERM_EN
    return (hi == 0) ? 1 : hi;
`else
    return (hi > W) ? 0 : W;
`endif
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    int             l;
    if (!resetn) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: z %0h with nothing expected", z);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          check("product", z, e);
          check("busy_cycles", 64'(busy_run), 64'(l));
          check("busy_low_at_done", {63'd0, busy}, 64'd0);
        end
        busy_run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy %0b required 0", busy);
    end
  endtask

  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic [2*W-1:0] ez);
    @(negedge clk);
    wait_idle();
    a     = oa;
    b     = ob;
    start = 1'b1;
    exp_q.push_back(ez);
    lat_q.push_back(exp_lat(ob));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic [2*W-1:0] vz;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{32'd7,         32'd6,         64'd42};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'h1234_5678, 32'd0,         64'd0};
    vecs[3] = '{32'h1234_5678, 32'd1,         64'h0000_0000_1234_5678};
    vecs[4] = '{32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[6] = '{32'hDEAD_BEEF, 32'd2,         64'h0000_0001_BD5B_7DDE};
    vecs[7] = '{32'd1,         32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    vecs[8] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int g;
    logic [W-1:0]   ra, rb;

    resetn = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    repeat (3) @(negedge clk);
    check("reset_z", z, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_state", {63'd0, fsm_state == MULTU_IDLE}, 64'd1);
    resetn = 1'b1;

    // Directed products: basic, carry-keeping max, zero, identity, etc.
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vz);
      drain();
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    do_op(32'd5, 32'd9, 64'd45);
`ifdef MULTU_EARLY_TERM_EN
    repeat (1) @(negedge clk);
`else
    repeat (3) @(negedge clk);
`endif
    check("busy_during_ignored_start", {63'd0, busy}, 64'd1);
    a     = 32'd3;
    b     = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 32'hFFFF_FFFF;
    b     = 32'hFFFF_FFFF;
    g = 0;
    while (!done && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done %0b required 1", done);
    end else begin
      a     = 32'd3;
      b     = 32'd3;
      start = 1'b1;
      exp_q.push_back(64'd9);
      lat_q.push_back(exp_lat(32'd3));
      @(negedge clk);
      start = 1'b0;
      check("back_to_back_accepted", {63'd0, busy}, 64'd1);
      check("result_hold", z, 64'd45);
    end
    drain();

    // Reset in the middle of an operation.
    do_op(32'd100, 32'hFFFF_0000, 64'h0000_0063_FF9C_0000);
    repeat (8) @(negedge clk);
    resetn = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    check("midreset_z", z, 64'd0);
    check("midreset_busy", {63'd0, busy}, 64'd0);
    check("midreset_done", {63'd0, done}, 64'd0);
    repeat (3) @(negedge clk);
    check("midreset_no_done", {63'd0, done}, 64'd0);
    resetn = 1'b1;
    do_op(32'd2, 32'd3, 64'd6);
    drain();

    // Random operands against a 64-bit reference product.
    for (int i = 0; i < 100; i++) begin
      ra = $urandom();
      rb = $urandom() >> $urandom_range(0, 31);
      do_op(ra, rb, 64'(ra) * 64'(rb));
    end
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_multu
